// File: rtl/bomb_blast_engine_if.sv
// Bus bundle between the arena initializer / player logic and bomb_blast_engine.
// The master side drives requests and player positions; the slave side returns maps and flags.
interface bomb_blast_engine_if;
    logic         tick;
    logic         load_arena;
    logic [99:0]  arena_init;
    logic         place_req;
    logic [6:0]   place_idx;
    logic [6:0]   p0_idx;
    logic [6:0]   p1_idx;
    logic [99:0]  arena;
    logic [99:0]  bombs;
    logic [99:0]  flame;
    logic         place_ack;
    logic         place_nak;
    logic         p0_hit;
    logic         p1_hit;
    logic         busy;

    modport master (
        output tick, load_arena, arena_init, place_req, place_idx, p0_idx, p1_idx,
        input  arena, bombs, flame, place_ack, place_nak, p0_hit, p1_hit, busy
    );

    modport slave (
        input  tick, load_arena, arena_init, place_req, place_idx, p0_idx, p1_idx,
        output arena, bombs, flame, place_ack, place_nak, p0_hit, p1_hit, busy
    );
endinterface

// File: rtl/bomb_blast_engine.sv
// Bomb arming, fuse countdown and four-way flame sweep over a 10x10 arena.
// Define BOMB_CHAIN_EN to let flames detonate other armed bombs; otherwise bombs block flames.
module bomb_blast_engine #(
    parameter int FUSE_TICKS  = 8,
    parameter int FLAME_TICKS = 2,
    parameter int RANGE       = 2,
    parameter int NUM_SLOTS   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bomb_blast_engine_if.slave bus
);
    // state  | meaning
    // IDLE   | accept placements, age flames, pick lowest expired bomb
    // CENTER | flame the origin cell and free its slot
    // SWEEP  | one target cell per clock, directions right, left, down, up
    // DONE   | reload the flame hold timer
    typedef enum logic [1:0] {IDLE, CENTER, SWEEP, DONE} state_t;

    state_t      state;
    logic [99:0] arena_q, bombs_q, flame_q;
    logic        ack_q, nak_q, hit0_q, hit1_q;
    logic [3:0]  flame_tmr;
    logic        slot_armed [NUM_SLOTS];
    logic [6:0]  slot_idx   [NUM_SLOTS];
    logic [3:0]  slot_fuse  [NUM_SLOTS];
    logic [1:0]  cur_slot;
    logic [6:0]  origin;
    logic [3:0]  orow, ocol;
    logic [1:0]  dir;
    logic [3:0]  step;

    logic        free_found, exp_found;
    logic [1:0]  free_slot, exp_slot;
    logic [6:0]  exp_idx;
    logic        place_ok;

    always_comb begin
        free_found = 1'b0;
        free_slot  = 2'd0;
        exp_found  = 1'b0;
        exp_slot   = 2'd0;
        exp_idx    = 7'd0;
        // descending scan so the lowest-numbered slot wins
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_armed[i]) begin
                free_found = 1'b1;
                free_slot  = 2'(i);
            end
            if (slot_armed[i] && slot_fuse[i] == 4'd0) begin
                exp_found = 1'b1;
                exp_slot  = 2'(i);
                exp_idx   = slot_idx[i];
            end
        end
        place_ok = (bus.place_idx <= 7'd99) && !arena_q[bus.place_idx]
                   && !bombs_q[bus.place_idx] && free_found;
    end

    logic [4:0] trow, tcol;
    logic       oob, is_wall, is_block, is_bomb, next_dir;
    logic [6:0] tgt;

    always_comb begin
        trow = {1'b0, orow};
        tcol = {1'b0, ocol};
        oob  = 1'b0;
        case (dir)
            2'd0: begin
                tcol = {1'b0, ocol} + {1'b0, step};
                oob  = tcol > 5'd9;
            end
            2'd1: begin
                oob  = step > ocol;
                tcol = {1'b0, ocol} - {1'b0, step};
            end
            2'd2: begin
                trow = {1'b0, orow} + {1'b0, step};
                oob  = trow > 5'd9;
            end
            default: begin
                oob  = step > orow;
                trow = {1'b0, orow} - {1'b0, step};
            end
        endcase
        tgt      = 7'(trow) * 7'd10 + 7'(tcol);
        is_wall  = oob || trow == 5'd0 || trow == 5'd9 || tcol == 5'd0 || tcol == 5'd9;
        is_block = !is_wall && arena_q[tgt];
        is_bomb  = !is_wall && !is_block && bombs_q[tgt];
`ifdef BOMB_CHAIN_EN
        next_dir = is_wall || is_block || (step == 4'(RANGE));
`else
        next_dir = is_wall || is_block || is_bomb || (step == 4'(RANGE));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            arena_q   <= '0;
            bombs_q   <= '0;
            flame_q   <= '0;
            ack_q     <= 1'b0;
            nak_q     <= 1'b0;
            hit0_q    <= 1'b0;
            hit1_q    <= 1'b0;
            flame_tmr <= 4'd0;
            cur_slot  <= 2'd0;
            origin    <= 7'd0;
            orow      <= 4'd0;
            ocol      <= 4'd0;
            dir       <= 2'd0;
            step      <= 4'd1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_armed[i] <= 1'b0;
                slot_idx[i]   <= 7'd0;
                slot_fuse[i]  <= 4'd0;
            end
        end else begin
            ack_q <= 1'b0;
            nak_q <= 1'b0;
            if (bus.load_arena) begin
                // load aborts any blast in flight and wipes all play state
                state     <= IDLE;
                arena_q   <= bus.arena_init;
                bombs_q   <= '0;
                flame_q   <= '0;
                hit0_q    <= 1'b0;
                hit1_q    <= 1'b0;
                flame_tmr <= 4'd0;
                nak_q     <= bus.place_req;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    slot_armed[i] <= 1'b0;
                    slot_fuse[i]  <= 4'd0;
                end
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (bus.tick && slot_armed[i] && slot_fuse[i] != 4'd0)
                        slot_fuse[i] <= slot_fuse[i] - 4'd1;
                if (bus.p0_idx <= 7'd99 && flame_q[bus.p0_idx]) hit0_q <= 1'b1;
                if (bus.p1_idx <= 7'd99 && flame_q[bus.p1_idx]) hit1_q <= 1'b1;
                if (state != IDLE) nak_q <= bus.place_req;

                case (state)
                    IDLE: begin
                        if (bus.place_req) begin
                            if (place_ok) begin
                                ack_q <= 1'b1;
                                bombs_q[bus.place_idx] <= 1'b1;
                                for (int i = 0; i < NUM_SLOTS; i++)
                                    if (2'(i) == free_slot) begin
                                        slot_armed[i] <= 1'b1;
                                        slot_idx[i]   <= bus.place_idx;
                                        slot_fuse[i]  <= 4'(FUSE_TICKS);
                                    end
                            end else begin
                                nak_q <= 1'b1;
                            end
                        end
                        if (bus.tick && flame_tmr != 4'd0) begin
                            flame_tmr <= flame_tmr - 4'd1;
                            if (flame_tmr == 4'd1) flame_q <= '0;
                        end
                        if (exp_found) begin
                            cur_slot <= exp_slot;
                            origin   <= exp_idx;
                            orow     <= 4'(exp_idx / 7'd10);
                            ocol     <= 4'(exp_idx % 7'd10);
                            state    <= CENTER;
                        end
                    end
                    CENTER: begin
                        flame_q[origin] <= 1'b1;
                        bombs_q[origin] <= 1'b0;
                        for (int i = 0; i < NUM_SLOTS; i++)
                            if (2'(i) == cur_slot) slot_armed[i] <= 1'b0;
                        dir   <= 2'd0;
                        step  <= 4'd1;
                        state <= SWEEP;
                    end
                    SWEEP: begin
                        if (!is_wall) begin
`ifdef BOMB_CHAIN_EN
                            flame_q[tgt] <= 1'b1;
`else
                            if (!is_bomb) flame_q[tgt] <= 1'b1;
`endif
                            if (is_block) arena_q[tgt] <= 1'b0;
                        end
`ifdef BOMB_CHAIN_EN
                        if (is_bomb)
                            for (int i = 0; i < NUM_SLOTS; i++)
                                if (slot_armed[i] && slot_idx[i] == tgt) slot_fuse[i] <= 4'd0;
`endif
                        if (next_dir) begin
                            if (dir == 2'd3) state <= DONE;
                            else begin
                                dir  <= dir + 2'd1;
                                step <= 4'd1;
                            end
                        end else begin
                            step <= step + 4'd1;
                        end
                    end
                    DONE: begin
                        flame_tmr <= 4'(FLAME_TICKS);
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.arena     = arena_q;
    assign bus.bombs     = bombs_q;
    assign bus.flame     = flame_q;
    assign bus.place_ack = ack_q;
    assign bus.place_nak = nak_q;
    assign bus.p0_hit    = hit0_q;
    assign bus.p1_hit    = hit1_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_bomb_blast_engine.sv
// Directed bench for bomb_blast_engine: placement table plus blast, chain, abort and reset sequences.
// Expectations for the chain scenario follow BOMB_CHAIN_EN.
module tb_bomb_blast_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bomb_blast_engine_if bus();
    bomb_blast_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [6:0] idx;
        logic       ack;
        logic       nak;
    } pvec_t;
    pvec_t pv [7];

    task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [99:0] bm(input int i);
        logic [99:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [99:0] border();
        logic [99:0] v;
        v = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                if (r == 0 || r == 9 || c == 0 || c == 9) v[r*10+c] = 1'b1;
        return v;
    endfunction

    task automatic place(input logic [6:0] idx);
        bus.place_idx = idx;
        bus.place_req = 1'b1;
        @(negedge clk);
        bus.place_req = 1'b0;
    endtask

    task automatic do_tick(input int n);
        for (int k = 0; k < n; k++) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    task automatic load(input logic [99:0] m);
        bus.arena_init = m;
        bus.load_arena = 1'b1;
        @(negedge clk);
        bus.load_arena = 1'b0;
    endtask

    task automatic wait_busy(input string nm);
        for (int k = 0; k < 50 && !bus.busy; k++) @(negedge clk);
        chk1(nm, bus.busy, 1'b1);
    endtask

    task automatic wait_quiet(input string nm);
        int q;
        q = 0;
        for (int k = 0; k < 200 && q < 3; k++) begin
            @(negedge clk);
            q = bus.busy ? 0 : q + 1;
        end
        chk1(nm, q >= 3, 1'b1);
    endtask

    logic [99:0] a1, a2, exp1, exp4a, exp4b;

    initial begin
        bus.tick = 1'b0; bus.load_arena = 1'b0; bus.arena_init = '0;
        bus.place_req = 1'b0; bus.place_idx = 7'd0;
        bus.p0_idx = 7'd23; bus.p1_idx = 7'd77;

        a1    = border() | bm(24) | bm(32);
        a2    = border() | bm(77);
        exp1  = bm(22) | bm(23) | bm(24) | bm(21) | bm(32) | bm(12);
        exp4a = bm(22) | bm(23) | bm(24) | bm(21) | bm(32) | bm(12);
        exp4b = bm(42) | bm(43) | bm(44) | bm(41) | bm(52) | bm(62) | bm(32) | bm(22);

        pv[0] = '{7'd24,  1'b0, 1'b1};
        pv[1] = '{7'd5,   1'b0, 1'b1};
        pv[2] = '{7'd22,  1'b1, 1'b0};
        pv[3] = '{7'd22,  1'b0, 1'b1};
        pv[4] = '{7'd120, 1'b0, 1'b1};
        pv[5] = '{7'd66,  1'b1, 1'b0};
        pv[6] = '{7'd77,  1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_arena", bus.arena, '0);
        chk("rst_bombs", bus.bombs, '0);
        chk("rst_flame", bus.flame, '0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_ack", bus.place_ack, 1'b0);
        chk1("rst_nak", bus.place_nak, 1'b0);
        chk1("rst_hit0", bus.p0_hit, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // single bomb at 22
        load(a1);
        chk("load_arena", bus.arena, a1);
        place(7'd22);
        chk1("s1_ack", bus.place_ack, 1'b1);
        chk1("s1_nak", bus.place_nak, 1'b0);
        chk("s1_bombs", bus.bombs, bm(22));
        @(negedge clk);
        chk1("s1_ack_pulse", bus.place_ack, 1'b0);
        do_tick(8);
        wait_busy("s1_start");
        place(7'd55);
        chk1("s1_nak_busy", bus.place_nak, 1'b1);
        wait_quiet("s1_end");
        chk("s1_flame", bus.flame, exp1);
        chk("s1_arena", bus.arena, border());
        chk("s1_bombs_clr", bus.bombs, '0);
        chk1("s1_hit0", bus.p0_hit, 1'b1);
        chk1("s1_hit1", bus.p1_hit, 1'b0);
        do_tick(1);
        chk("s1_flame_hold", bus.flame, exp1);
        do_tick(1);
        chk("s1_flame_clr", bus.flame, '0);
        chk1("s1_hit0_sticky", bus.p0_hit, 1'b1);

        // placement accept/reject table
        load(a1);
        for (int i = 0; i < 7; i++) begin
            place(pv[i].idx);
            chk1($sformatf("pv%0d_ack", i), bus.place_ack, pv[i].ack);
            chk1($sformatf("pv%0d_nak", i), bus.place_nak, pv[i].nak);
        end
        chk("pv_bombs", bus.bombs, bm(22) | bm(66));

        // bombs at 22 and 42, second armed three ticks later
        load(border());
        chk1("s4_hit_clr", bus.p0_hit, 1'b0);
        place(7'd22);
        do_tick(3);
        place(7'd42);
        do_tick(5);
        wait_quiet("s4_end1");
`ifdef BOMB_CHAIN_EN
        chk("s4_flame_chain", bus.flame, exp4a | exp4b);
        chk("s4_bombs_chain", bus.bombs, '0);
`else
        chk("s4_flame1", bus.flame, exp4a);
        chk("s4_bombs1", bus.bombs, bm(42));
        do_tick(3);
        wait_quiet("s4_end2");
        chk("s4_flame2", bus.flame, exp4b);
        chk("s4_bombs2", bus.bombs, '0);
`endif

        // load during sweep aborts the blast
        load(a1);
        place(7'd44);
        do_tick(8);
        wait_busy("s5_start");
        @(negedge clk);
        @(negedge clk);
        chk1("s5_in_sweep", bus.busy, 1'b1);
        bus.arena_init = a2;
        bus.load_arena = 1'b1;
        bus.place_idx  = 7'd33;
        bus.place_req  = 1'b1;
        @(negedge clk);
        bus.load_arena = 1'b0;
        bus.place_req  = 1'b0;
        chk1("s5_busy", bus.busy, 1'b0);
        chk("s5_flame", bus.flame, '0);
        chk("s5_arena", bus.arena, a2);
        chk("s5_bombs", bus.bombs, '0);
        chk1("s5_nak", bus.place_nak, 1'b1);

        // async reset mid-fuse
        place(7'd55);
        chk1("s6_ack", bus.place_ack, 1'b1);
        do_tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_arena", bus.arena, '0);
        chk("s6_bombs", bus.bombs, '0);
        chk("s6_flame", bus.flame, '0);
        chk1("s6_busy", bus.busy, 1'b0);
        chk1("s6_hit0", bus.p0_hit, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bomb_blast_engine.md
Name: bomb_blast_engine

Overview:
- Sits directly downstream of the arena initializer. Latches its 100-bit 10x10 arena map and owns the live copy during play.
- Arms bombs on player request and counts each fuse down in game ticks.
- On expiry, sweeps flames one cell per clock in four directions and destroys breakable blocks. Flags players standing in flame.
- Cell index = row*10 + col. Border cells (row 0/9, col 0/9) are indestructible walls; every other set arena bit is a breakable block.

Parameters:
- FUSE_TICKS, 8: ticks from arming to detonation (1..15).
- FLAME_TICKS, 2: ticks the flame map is held after the last blast (1..15).
- RANGE, 2: flame reach per direction in cells (1..8).
- NUM_SLOTS, 2: simultaneous armed bombs (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-tick strobe
- load_arena  in  1  pulse; copy arena_init into the live arena
- arena_init  in  100  map from the initializer
- place_req  in  1  pulse; request a bomb at place_idx
- place_idx  in  7  target cell 0..99
- p0_idx  in  7  player 0 cell
- p1_idx  in  7  player 1 cell
- arena  out  100  live wall/block map
- bombs  out  100  armed-bomb map
- flame  out  100  active flame map
- place_ack  out  1  one-cycle accept pulse
- place_nak  out  1  one-cycle reject pulse
- p0_hit  out  1  sticky; player 0 was in flame
- p1_hit  out  1  sticky; player 1 was in flame
- busy  out  1  high while not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: arena, bombs and flame = 0; all pulses, hit flags and busy = 0.
  - Internal: all slots free; state = IDLE.
- load_arena: in any state, on the next edge arena <= arena_init. Slots, bombs, flame, hits and the flame timer are cleared, and state returns to IDLE (aborts a blast mid-sweep). A place_req in the same cycle gets nak.
- Placement:
  - Evaluated only in IDLE; ack or nak is registered one cycle after place_req.
  - Accept iff all hold: place_idx <= 99; arena bit = 0; bombs bit = 0; a slot is free.
  - On accept: lowest free slot gets idx and fuse = FUSE_TICKS, and the bombs bit is set.
  - Outside IDLE, always nak.
- Fuse: on each tick, every armed slot with fuse > 0 decrements, in every state. A slot at 0 is expired.
- FSM:
  - IDLE: if any slot is expired, pick the lowest-numbered one, go to CENTER.
  - CENTER (1 clk): set the flame bit at the bomb cell, clear its bombs bit, free the slot; dir = right, step = 1.
  - SWEEP (1 clk per cell): target = origin offset by step in dir.
    - Wall: no flame; next dir.
    - Block: set flame, clear arena bit; next dir.
    - Bomb cell: set flame; set that slot's fuse to 0; continue.
    - Empty: set flame; continue.
    - After step RANGE, move to the next dir. Direction order: right, left, down, up. After up, go to DONE.
    - A step that would leave its row or column is treated as a wall.
  - DONE (1 clk): load the flame timer with FLAME_TICKS; go to IDLE.
  - Worst-case blast latency: 4*RANGE + 2 clocks.
- Flame clear: in IDLE with the timer > 0, each tick decrements it; at 0, flame clears. A new blast reloads the timer, so flames accumulate.
- Hits: every cycle, if flame[pN_idx] = 1, then pN_hit <= 1. Hits are cleared only by reset or load_arena.
- Simultaneous expiries are serialized lowest slot first, one blast per pass through IDLE.
- A tick arriving during SWEEP still decrements fuses but not the flame timer.

Optional Feature:
- Macro: BOMB_CHAIN_EN.
- Defined: a flame reaching an armed bomb forces that slot's fuse to 0 (chain detonation) and the sweep continues past it.
- Undefined: the bomb cell is treated as a wall. No flame is set there, its fuse is untouched, and the sweep moves to the next direction.

Test Plan:
- Reset, then load_arena with border + blocks {24,32}; place_req idx 22 -> ack next cycle, bombs[22]=1. After 8 ticks + sweep: flame = {22,23,24,21,32,12}, arena[24]=arena[32]=0, bombs=0, walls 20 and 2 unflamed.
- place_req idx 24 (block), idx 5 (wall), idx 22 twice, third bomb with NUM_SLOTS=2 -> nak for each rejected request, one cycle later.
- p0_idx=23 during the scenario-1 blast -> p0_hit=1 and stays 1 after flame clears FLAME_TICKS ticks after DONE; p1_idx=77 -> p1_hit=0.
- Bombs at 22 and 42, RANGE=2, 42 armed 3 ticks later. With BOMB_CHAIN_EN: both detonate on the first expiry, flame includes 52 and 62. Without: 42 detonates 3 ticks later.
- Assert load_arena during SWEEP -> next cycle busy=0, flame=0, arena=arena_init, bombs=0.
- Assert rst_n low mid-fuse -> all outputs 0 immediately, without waiting for a clock edge.
